s_dlyarb: RTL and testbench
===========================

# s_dlyarb

Round-robin arbiter and sequencer that shares one fixed-latency SIZE-bit delay pipeline among NREQ requesters. Each accepted beat enters the shared pipeline tagged with its requester ID. The beat exits exactly DELAY cycles later with that tag. The block sits in front of shared synchronous delay/pipeline resources. It replaces per-requester delay lines when traffic is sparse. Optional burst locking lets one requester keep the pipe for up to BURST consecutive beats.

## Interface
- SIZE, 8, data width per beat
- DELAY, 3, pipeline latency in cycles; legal range 1..16
- NREQ, 4, number of requesters; legal range 2..8
- IDW, 2, tag width; must equal clog2(NREQ), and 1 when NREQ=2
- BURST, 1, maximum consecutive beats per grant; 1 means pure round robin
- clk  input  1  clock; all flops rising-edge
- rst_n  input  1  asynchronous active-low reset
- hold  input  1  when high, no grants are issued; the pipeline keeps advancing
- req  input  NREQ  per-requester beat valid
- req_dat  input  NREQ*SIZE  requester i data on bits [i*SIZE +: SIZE]
- gnt  output  NREQ  one-hot or zero; beat i is accepted on a rising edge where req[i]&gnt[i]
- out_vld  output  1  tagged beat exits the pipeline
- out_id  output  IDW  requester index of the exiting beat
- out_dat  output  SIZE  data of the exiting beat
- busy  output  1  at least one valid beat is inside the pipeline

## Operation
- gnt is combinational from req, hold and registered state. With hold=1, gnt=0. A requester never sees gnt without its own req.
- State, all reset to 0:
  - ptr: round-robin start index, IDW bits
  - own_vld: a burst is currently locked
  - owner: the locked requester, IDW bits
  - cnt: beats granted in the current burst, clog2(BURST+1) bits
- Grant selection, evaluated each cycle with hold=0:
  - Burst continue: if own_vld and req[owner] are both high, gnt[owner]=1.
  - New winner: otherwise the winner w is the first set req bit scanning ptr, ptr+1, ..., wrapping modulo NREQ.
- Updates on a burst-continue grant:
  - cnt <= cnt+1.
  - If cnt+1 == BURST, clear own_vld.
- Updates on a new-winner grant:
  - ptr <= (w+1) mod NREQ. This wrap must be correct for a non-power-of-2 NREQ.
  - If BURST>1: own_vld <= 1, owner <= w, cnt <= 1.
- Early burst end: if own_vld=1 and req[owner]=0, clear own_vld in that cycle. The new-winner scan runs in the same cycle, so no bubble is inserted.
- Hold: while hold=1, ptr, own_vld, owner and cnt are frozen. Only the pipeline advances.
- Pipeline:
  - DELAY stages, each holding {vld, id, dat}.
  - Stage 0 loads {|(req&gnt), index of gnt, req_dat of the granted requester}.
  - On non-accept cycles, stage 0 loads vld=0 and dat=0.
  - Stage DELAY-1 drives out_vld, out_id and out_dat directly from flops.
- busy is the OR of all stage vld bits, registered and aligned with the stage contents.
- Pipeline capacity:
  - There is no backpressure on the output. The consumer must accept every out_vld beat.
  - At most one beat is accepted per cycle, so the pipeline can never overflow.

## Timing
- Reset (rst_n=0, asynchronous): all stages cleared; out_vld=0, out_id=0, out_dat=0, busy=0; ptr=0, own_vld=0, cnt=0; gnt=0 while rst_n=0.
- Reset asserted mid-operation discards all in-flight beats. No out_vld pulse appears for them after release.
- The first grant after reset release follows the rule above with ptr=0.
- Latency: a beat accepted at edge t is presented on out_vld/out_id/out_dat after edge t+DELAY-1. It is stable for one cycle. With DELAY=1 it is visible in the cycle after acceptance.
- Throughput: one beat per cycle. Back-to-back beats from different requesters exit back-to-back in acceptance order.
- With only one requester active, it is granted every cycle regardless of BURST. ptr wraps back to it each time.
- Simultaneous hold rise and burst in progress: the burst resumes after hold falls, with cnt preserved.

## Test plan
- Reset, DELAY=3, NREQ=4, BURST=1: req=4'b1111 held, dat_i=8'hA0+i.
  - gnt sequence: 0001, 0010, 0100, 1000, 0001.
  - out_id sequence 0,1,2,3 starts three cycles after the first grant, with out_dat A0..A3.
  - busy rises one cycle after the first accept.
- Non-power-of-2 NREQ=3, all requesting: grants cycle 0,1,2,0. ptr never reaches 3.
- BURST=3, req=4'b0101 held:
  - grants 0,0,0,2,2,2,0.
  - Dropping req[0] after its 2nd beat: next cycle grants requester 2 with no idle cycle.
- hold: assert hold for 2 cycles mid-burst (cnt=1).
  - gnt=0 during hold; the pipeline still drains.
  - After release, 2 more owner beats, then the next requester.
- Reset mid-flight: 3 beats in the pipeline, pulse rst_n low for one cycle (asynchronous). Then out_vld=0 and busy=0 immediately, and no stale beats emerge afterwards.
- DELAY=1, single requester streaming 8'h00..8'h0F: out_dat follows one cycle later. No beats are lost or duplicated.

Source files
------------

// File: rtl/s_dlyarb.sv
// rtl/s_dlyarb.sv - round-robin arbiter sharing one fixed-latency tagged delay pipeline
// Optional burst lock lets one requester keep the pipe for up to BURST beats.
module s_dlyarb #(
  parameter int SIZE  = 8,
  parameter int DELAY = 3,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int BURST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] req_dat,
  output logic [NREQ-1:0]      gnt,
  output logic                 out_vld,
  output logic [IDW-1:0]       out_id,
  output logic [SIZE-1:0]      out_dat,
  output logic                 busy
);

  localparam int CW = $clog2(BURST + 1);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic            own_vld_q, own_vld_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [IDW-1:0]  win;
  logic            win_found;
  logic [IDW-1:0]  gnt_id;
  logic            acc;
  logic [SIZE-1:0] acc_dat;

  logic [DELAY-1:0] vld_q, vld_d;
  logic [IDW-1:0]   id_q  [DELAY];
  logic [SIZE-1:0]  dat_q [DELAY];
  logic             busy_q;

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && req[(int'(ptr_q) + k) % NREQ]) begin
        win       = IDW'((int'(ptr_q) + k) % NREQ);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    own_vld_d = own_vld_q;
    cnt_d     = cnt_q;
    if (rst_n && !hold) begin
      if (own_vld_q && req[owner_q]) begin
        gnt[owner_q] = 1'b1;
        gnt_id       = owner_q;
        cnt_d        = cnt_q + CW'(1);
        if (int'(cnt_q) + 1 == BURST) own_vld_d = 1'b0;
      end else begin
        // a lost or finished burst falls straight through to the scan, so no bubble
        own_vld_d = 1'b0;
        if (win_found) begin
          gnt[win] = 1'b1;
          gnt_id   = win;
          ptr_d    = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
          if (BURST > 1) begin
            own_vld_d = 1'b1;
            owner_d   = win;
            cnt_d     = CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      owner_q   <= '0;
      own_vld_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      own_vld_q <= own_vld_d;
      cnt_q     <= cnt_d;
    end
  end

  assign acc     = |(req & gnt);
  assign acc_dat = acc ? req_dat[int'(gnt_id)*SIZE +: SIZE] : '0;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = acc;
    for (int i = 1; i < DELAY; i++) vld_d[i] = vld_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < DELAY; i++) begin
        id_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      busy_q   <= |vld_d;
      id_q[0]  <= acc ? gnt_id : '0;
      dat_q[0] <= acc_dat;
      for (int i = 1; i < DELAY; i++) begin
        id_q[i]  <= id_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[DELAY-1];
  assign out_id  = id_q[DELAY-1];
  assign out_dat = dat_q[DELAY-1];
  assign busy    = busy_q;

endmodule

// File: tb/tb_s_dlyarb.sv
// tb/tb_s_dlyarb.sv - scoreboard bench for s_dlyarb over three parameter sets
module tb_s_dlyarb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int id;
    int dat;
    int cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // A: DELAY=3 NREQ=4 BURST=1
  logic        a_rst, a_hold, a_vld, a_busy;
  logic [3:0]  a_req, a_gnt;
  logic [31:0] a_dat;
  logic [1:0]  a_id;
  logic [7:0]  a_odat;

  s_dlyarb #(.SIZE(8), .DELAY(3), .NREQ(4), .IDW(2), .BURST(1)) u_a (
    .clk(clk), .rst_n(a_rst), .hold(a_hold), .req(a_req), .req_dat(a_dat),
    .gnt(a_gnt), .out_vld(a_vld), .out_id(a_id), .out_dat(a_odat), .busy(a_busy)
  );

  // B: DELAY=1 NREQ=3 BURST=1
  logic        b_rst, b_hold, b_vld, b_busy;
  logic [2:0]  b_req, b_gnt;
  logic [23:0] b_dat;
  logic [1:0]  b_id;
  logic [7:0]  b_odat;

  s_dlyarb #(.SIZE(8), .DELAY(1), .NREQ(3), .IDW(2), .BURST(1)) u_b (
    .clk(clk), .rst_n(b_rst), .hold(b_hold), .req(b_req), .req_dat(b_dat),
    .gnt(b_gnt), .out_vld(b_vld), .out_id(b_id), .out_dat(b_odat), .busy(b_busy)
  );

  // C: DELAY=2 NREQ=4 BURST=3
  logic        c_rst, c_hold, c_vld, c_busy;
  logic [3:0]  c_req, c_gnt;
  logic [31:0] c_dat;
  logic [1:0]  c_id;
  logic [7:0]  c_odat;

  s_dlyarb #(.SIZE(8), .DELAY(2), .NREQ(4), .IDW(2), .BURST(3)) u_c (
    .clk(clk), .rst_n(c_rst), .hold(c_hold), .req(c_req), .req_dat(c_dat),
    .gnt(c_gnt), .out_vld(c_vld), .out_id(c_id), .out_dat(c_odat), .busy(c_busy)
  );

  // burst / early-end / hold sequence, hand-derived grants
  logic [3:0] c_req_v  [15] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101,
                                4'b0101, 4'b0101, 4'b0101, 4'b0100, 4'b0101,
                                4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000};
  logic       c_hold_v [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0] c_gnt_v  [15] = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100,
                                4'b0100, 4'b0001, 4'b0001, 4'b0100, 4'b0000,
                                4'b0000, 4'b0100, 4'b0100, 4'b0001, 4'b0000};

  always @(negedge clk) if (a_vld) begin
    if (qa.size() == 0) chk("a_unexpected_vld", 32'(a_vld), 32'(0));
    else begin
      exp_t e;
      e = qa.pop_front();
      chk("a_out_id", 32'(a_id), 32'(e.id));
      chk("a_out_dat", 32'(a_odat), 32'(e.dat));
      chk("a_out_cycle", 32'(cyc), 32'(e.cyc));
    end
  end

  always @(negedge clk) if (b_vld) begin
    if (qb.size() == 0) chk("b_unexpected_vld", 32'(b_vld), 32'(0));
    else begin
      exp_t e;
      e = qb.pop_front();
      chk("b_out_id", 32'(b_id), 32'(e.id));
      chk("b_out_dat", 32'(b_odat), 32'(e.dat));
      chk("b_out_cycle", 32'(cyc), 32'(e.cyc));
    end
  end

  always @(negedge clk) if (c_vld) begin
    if (qc.size() == 0) chk("c_unexpected_vld", 32'(c_vld), 32'(0));
    else begin
      exp_t e;
      e = qc.pop_front();
      chk("c_out_id", 32'(c_id), 32'(e.id));
      chk("c_out_dat", 32'(c_odat), 32'(e.dat));
      chk("c_out_cycle", 32'(cyc), 32'(e.cyc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_hold = 1'b0; b_hold = 1'b0; c_hold = 1'b0;
    a_req = 4'hF; a_dat = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    b_req = '0; b_dat = '0; c_req = '0; c_dat = '0;

    repeat (2) @(negedge clk);
    chk("a_rst_gnt", 32'(a_gnt), 32'(0));
    chk("a_rst_vld", 32'(a_vld), 32'(0));
    chk("a_rst_id", 32'(a_id), 32'(0));
    chk("a_rst_dat", 32'(a_odat), 32'(0));
    chk("a_rst_busy", 32'(a_busy), 32'(0));
    chk("c_rst_vld", 32'(c_vld), 32'(0));

    @(posedge clk); #1;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("a_gnt_rr", 32'(a_gnt), 32'(1 << (k % 4)));
      if (k == 0) chk("a_busy_before", 32'(a_busy), 32'(0));
      if (k == 1) chk("a_busy_rise", 32'(a_busy), 32'(1));
      qa.push_back('{k % 4, 160 + (k % 4), cyc + 3});
      @(posedge clk); #1;
    end

    // three beats in flight; async reset must discard them
    a_req = 4'h0;
    #1 a_rst = 1'b0;
    qa.delete();
    a_req = 4'hF;
    #1;
    chk("a_midrst_vld", 32'(a_vld), 32'(0));
    chk("a_midrst_busy", 32'(a_busy), 32'(0));
    chk("a_midrst_dat", 32'(a_odat), 32'(0));
    @(negedge clk);
    chk("a_midrst_gnt", 32'(a_gnt), 32'(0));
    @(posedge clk); #1;
    a_req = 4'h0;
    a_rst = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("a_post_rst_busy", 32'(a_busy), 32'(0));

    b_req = 3'b111;
    b_dat = {8'h22, 8'h11, 8'h00};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("b_gnt_rr3", 32'(b_gnt), 32'(1 << (k % 3)));
      qb.push_back('{k % 3, 17 * (k % 3), cyc + 1});
      @(posedge clk); #1;
    end
    b_req = 3'b010;
    for (int k = 0; k < 16; k++) begin
      b_dat = {8'h22, 8'(k), 8'h00};
      @(negedge clk);
      chk("b_gnt_single", 32'(b_gnt), 32'(3'b010));
      qb.push_back('{1, k, cyc + 1});
      @(posedge clk); #1;
    end
    b_req = '0;
    repeat (3) @(posedge clk);
    #1;

    for (int s = 0; s < 15; s++) begin
      c_req  = c_req_v[s];
      c_hold = c_hold_v[s];
      c_dat  = {8'(48 + s), 8'(32 + s), 8'(16 + s), 8'(s)};
      @(negedge clk);
      chk($sformatf("c_gnt_step%0d", s), 32'(c_gnt), 32'(c_gnt_v[s]));
      for (int i = 0; i < 4; i++)
        if (c_gnt_v[s][i]) qc.push_back('{i, 16 * i + s, cyc + 2});
      @(posedge clk); #1;
    end
    c_req = '0;
    c_hold = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    chk("a_queue_empty", 32'(qa.size()), 32'(0));
    chk("b_queue_empty", 32'(qb.size()), 32'(0));
    chk("c_queue_empty", 32'(qc.size()), 32'(0));
    chk("b_final_busy", 32'(b_busy), 32'(0));
    chk("c_final_busy", 32'(c_busy), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
